// File: rtl/pll_frac_divider_if.sv
// pll_frac_divider_if: ratio-control inputs and divided-clock outputs of the fractional-N feedback divider
interface pll_frac_divider_if #(
    parameter int W  = 8,
    parameter int FW = 8
);
    logic          en;
    logic [W-1:0]  n_int;
    logic [FW-1:0] n_frac;
    logic          load;
    logic          vout;
    logic          pulse;
    logic          load_ack;
    logic [W:0]    cur_n;

    modport master (
        output en, n_int, n_frac, load,
        input  vout, pulse, load_ack, cur_n
    );

    modport slave (
        input  en, n_int, n_frac, load,
        output vout, pulse, load_ack, cur_n
    );
endinterface

// File: rtl/pll_frac_divider.sv
// pll_frac_divider: integer/fractional-N VCO feedback divider with shadowed ratio applied at period boundaries
module pll_frac_divider #(
    parameter int W       = 8,
    parameter int FW      = 8,
    parameter int FRAC_EN = 1
) (
    input logic               clk,
    input logic               rst,
    pll_frac_divider_if.slave bus
);
    logic [W:0]    cnt, cur_n, cnt_nx, cur_nx;
    logic [FW-1:0] acc, acc_sum, sh_frac, nx_frac;
    logic [W-1:0]  sh_int, nx_int, clamp_int;
    logic          pending, vout, pulse, load_ack, bnd, carry, cy;

    always_comb begin
        clamp_int      = (bus.n_int < W'(2)) ? W'(2) : bus.n_int;
        nx_int         = bus.load ? clamp_int : sh_int;
        nx_frac        = bus.load ? bus.n_frac : sh_frac;
        bnd            = bus.en && (cnt == cur_n - (W+1)'(1));
        {carry, acc_sum} = {1'b0, acc} + {1'b0, nx_frac};
        cy             = (FRAC_EN != 0) && carry;
        cur_nx         = bnd ? {1'b0, nx_int} + {{W{1'b0}}, cy} : cur_n;
        cnt_nx         = bnd ? '0 : cnt + (W+1)'(1);
    end

    // reset parks cnt on the terminal count so the first enabled edge opens a period
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_int   <= clamp_int;
            sh_frac  <= bus.n_frac;
            cur_n    <= {1'b0, clamp_int};
            cnt      <= {1'b0, clamp_int} - (W+1)'(1);
            acc      <= '0;
            pending  <= 1'b0;
            vout     <= 1'b0;
            pulse    <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            sh_int   <= nx_int;
            sh_frac  <= nx_frac;
            pending  <= bnd ? 1'b0 : (pending | bus.load);
            pulse    <= bnd;
            load_ack <= bnd && (pending || bus.load);
            if (bus.en) begin
                cnt   <= cnt_nx;
                cur_n <= cur_nx;
                vout  <= cnt_nx < (cur_nx >> 1);
                if (bnd) acc <= acc_sum;
            end
        end
    end

    assign bus.vout     = vout;
    assign bus.pulse    = pulse;
    assign bus.load_ack = load_ack;
    assign bus.cur_n    = cur_n;
endmodule
